// File: rtl/ps2_host_tx_if.sv
// Command/status and open-drain pin bundle between a PS/2 host transmitter and its user.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter using the request-to-send sequence.
// Open-drain: an _oe output high means pull that pin low.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ps2_host_tx_if.slave  bus
);
    // state     | meaning
    // IDLE      | lines released, ready for a byte
    // INHIBIT   | hold PS2_CLK low
    // RTS       | clk and data both low (start bit), one cycle
    // XMIT      | device clocks out start, data, parity, stop
    // ACK       | sample device ack on next falling edge
    // WAIT_IDLE | wait for both lines high before signalling done
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_XMIT, S_ACK, S_WAIT_IDLE
    } state_t;

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          fall;
    logic          timeout;

    // Synchronizers come out of reset at the idle-high level so no false fall is seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= bus.ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= bus.ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q;
    assign timeout = (to_cnt_q == TO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    shift_d   = {~^bus.tx_data, bus.tx_data};
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    to_cnt_d  = '0;
                    dat_oe_d  = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + IW'(1);
                end
            end
            S_RTS: begin
                state_d = S_XMIT;
            end
            S_XMIT: begin
                if (timeout) begin
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    if (fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                            state_d  = S_ACK;
                        end else begin
                            // Shift register holds data LSB first with parity in bit 8.
                            dat_oe_d = ~shift_q[0];
                            shift_d  = {1'b0, shift_q[8:1]};
                        end
                    end
                end
            end
            S_ACK: begin
                if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    if (fall) begin
                        if (dat_sync_q) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    if (clk_sync_q && dat_sync_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign bus.tx_ready   = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_RTS);
    assign bus.ps2_dat_oe = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pin model plus a behavioural PS/2 device.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TOUT = 1500;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic clk_line, dat_line;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #10 clk_i = ~clk_i;

    assign clk_line = ~(bus.ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(bus.ps2_dat_oe | dev_dat_low);
    assign bus.ps2_clk_in = clk_line;
    assign bus.ps2_dat_in = dat_line;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [7:0] data; logic par; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       exp_par;
        logic       exp_done;
        logic       exp_err;
    } vec_t;
    vec_t vecs[6];

    int m_inh, m_rts, m_dn, m_er, m_both;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send(input logic [7:0] d, input bit push, input logic p);
        int w = 0;
        @(negedge clk_i);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        while (!bus.tx_ready && w < 10000) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 10000) bound_fail("send_accept");
        if (push) sb.push_back('{d, p});
        @(posedge clk_i);
        #1 bus.tx_valid = 1'b0;
    endtask

    // Device side: clocks out 11 bits, samples data at the end of each low phase.
    task automatic dev_rx(input logic ack_bit);
        logic [10:0] fr = '0;
        int w = 0;
        int h;
        exp_t e;
        while (!(clk_line && !dat_line) && w < 20000) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 20000) begin
            bound_fail("dev_rts_wait");
            return;
        end
        fr[0] = dat_line;
        repeat (5) @(negedge clk_i);
        for (int k = 1; k <= 11; k++) begin
            h = $urandom_range(15, 25);
            dev_clk_low = 1'b1;
            repeat (h) @(negedge clk_i);
            if (k <= 10) fr[k] = dat_line;
            dev_clk_low = 1'b0;
            if (k == 11) dev_dat_low = 1'b0;
            repeat (h / 2) @(negedge clk_i);
            if (k == 10) dev_dat_low = ~ack_bit;
            repeat (h - h / 2) @(negedge clk_i);
        end
        if (sb.size() == 0) begin
            bound_fail("sb_underflow");
        end else begin
            e = sb.pop_front();
            chk("rx_data",   {24'd0, fr[8:1]}, {24'd0, e.data});
            chk("rx_parity", {31'd0, fr[9]},   {31'd0, e.par});
            chk("rx_stop",   {31'd0, fr[10]},  32'd1);
        end
    endtask

    task automatic monitor(output int inh, output int rts, output int dn,
                           output int er, output int both);
        int cyc = 0;
        int tail = -1;
        inh = 0; rts = 0; dn = 0; er = 0; both = 0;
        while (cyc < 8000 && tail != 0) begin
            @(negedge clk_i);
            cyc++;
            if (bus.ps2_clk_oe && !bus.ps2_dat_oe) inh++;
            if (bus.ps2_clk_oe && bus.ps2_dat_oe)  rts++;
            if (bus.done)  dn++;
            if (bus.error) er++;
            if (bus.done && bus.error) both++;
            if (tail < 0 && (bus.done || bus.error)) tail = 5;
            else if (tail > 0) tail--;
        end
        if (tail != 0) bound_fail("monitor_end");
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hF4, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk_i);
        chk("rst_clk_oe",   {31'd0, bus.ps2_clk_oe}, 32'd0);
        chk("rst_dat_oe",   {31'd0, bus.ps2_dat_oe}, 32'd0);
        chk("rst_tx_ready", {31'd0, bus.tx_ready},   32'd1);
        chk("rst_busy",     {31'd0, bus.busy},       32'd0);
        chk("rst_done",     {31'd0, bus.done},       32'd0);
        chk("rst_error",    {31'd0, bus.error},      32'd0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        for (int i = 0; i < 6; i++) begin
            fork
                send(vecs[i].data, 1'b1, vecs[i].exp_par);
                dev_rx(vecs[i].ack);
                monitor(m_inh, m_rts, m_dn, m_er, m_both);
            join
            chk("inhibit_len", m_inh, INH);
            chk("rts_len",     m_rts, 32'd1);
            chk("done_cnt",    m_dn,  {31'd0, vecs[i].exp_done});
            chk("error_cnt",   m_er,  {31'd0, vecs[i].exp_err});
            chk("done_and_error", m_both, 32'd0);
            chk("end_tx_ready", {31'd0, bus.tx_ready},   32'd1);
            chk("end_clk_oe",   {31'd0, bus.ps2_clk_oe}, 32'd0);
            chk("end_dat_oe",   {31'd0, bus.ps2_dat_oe}, 32'd0);
            repeat (10) @(negedge clk_i);
        end

        // Device never clocks: error must come exactly TOUT cycles after RTS exit.
        fork
            send(8'h55, 1'b0, 1'b0);
            begin
                int w = 0;
                int n = 0;
                int dn = 0;
                while (!(bus.ps2_clk_oe && bus.ps2_dat_oe) && w < 5000) begin
                    @(negedge clk_i);
                    w++;
                end
                if (w >= 5000) bound_fail("timeout_rts_wait");
                @(negedge clk_i);
                chk("xmit_start_dat_oe", {31'd0, bus.ps2_dat_oe}, 32'd1);
                while (!bus.error && n < TOUT + 200) begin
                    @(negedge clk_i);
                    n++;
                    if (bus.done) dn++;
                end
                chk("timeout_cycles", n, TOUT);
                chk("timeout_clk_oe", {31'd0, bus.ps2_clk_oe}, 32'd0);
                chk("timeout_dat_oe", {31'd0, bus.ps2_dat_oe}, 32'd0);
                chk("timeout_busy",   {31'd0, bus.busy},       32'd0);
                chk("timeout_no_done", dn, 32'd0);
            end
        join
        repeat (10) @(negedge clk_i);

        // Reset in the middle of XMIT releases lines at once and produces no pulse.
        fork
            send(8'h96, 1'b0, 1'b0);
            begin
                int w = 0;
                int pulses = 0;
                while (!(clk_line && !dat_line) && w < 5000) begin
                    @(negedge clk_i);
                    w++;
                end
                if (w >= 5000) bound_fail("rst_xmit_wait");
                repeat (5) @(negedge clk_i);
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk_i);
                dev_clk_low = 1'b0;
                repeat (20) @(negedge clk_i);
                chk("pre_rst_dat_oe", {31'd0, bus.ps2_dat_oe}, 32'd1);
                dev_clk_low = 1'b1;
                #3 rst_i = 1'b1;
                #1;
                chk("rst_mid_clk_oe",   {31'd0, bus.ps2_clk_oe}, 32'd0);
                chk("rst_mid_dat_oe",   {31'd0, bus.ps2_dat_oe}, 32'd0);
                chk("rst_mid_tx_ready", {31'd0, bus.tx_ready},   32'd1);
                dev_clk_low = 1'b0;
                repeat (3) @(negedge clk_i);
                rst_i = 1'b0;
                repeat (100) begin
                    @(negedge clk_i);
                    if (bus.done || bus.error) pulses++;
                end
                chk("rst_mid_no_pulse", pulses, 32'd0);
            end
        join

        // tx_valid held with changing data: only the latched byte goes out, next after done.
        fork
            begin
                int w = 0;
                @(negedge clk_i);
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'hA5;
                sb.push_back('{8'hA5, 1'b1});
                @(posedge clk_i);
                while (w < 8000) begin
                    @(negedge clk_i);
                    w++;
                    if (!bus.busy) break;
                    bus.tx_data = 8'($urandom);
                end
                if (w >= 8000) bound_fail("held_valid_wait");
                chk("next_accept_after_done", {31'd0, bus.done}, 32'd1);
                bus.tx_data = 8'h3D;
                sb.push_back('{8'h3D, 1'b0});
                @(posedge clk_i);
                #1 bus.tx_valid = 1'b0;
            end
            begin
                dev_rx(1'b0);
                dev_rx(1'b0);
            end
        join
        begin
            int w = 0;
            int dn = 0;
            while (w < 200) begin
                @(negedge clk_i);
                w++;
                if (bus.done) dn++;
                if (bus.tx_ready && w > 10) break;
            end
            chk("held_final_idle", {31'd0, bus.tx_ready}, 32'd1);
        end
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the host-initiated request-to-send sequence. It sits beside the keyboard receive/decoder path and shares the same PS2_CLK/PS2_DAT pins. Pin access is open-drain: the top level drives each pin low when its _oe output is high, and releases it (high-Z) otherwise.

Parameters:
INHIBIT_CYCLES, 5000, clock-low inhibit time in CLK cycles (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum CLK cycles from clock release to ack sample (15 ms at 50 MHz).

Ports:
CLK  input  1  system clock, 50 MHz
RST  input  1  asynchronous, active-high reset
tx_data  input  8  command byte to send
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high in IDLE only; a byte is accepted on the cycle tx_valid & tx_ready
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: byte sent and device ack received
error  output  1  one-cycle pulse: no ack (ack=1) or timeout
ps2_clk_in  input  1  raw PS2_CLK pin level
ps2_dat_in  input  1  raw PS2_DAT pin level
ps2_clk_oe  output  1  1 = pull PS2_CLK low
ps2_dat_oe  output  1  1 = pull PS2_DAT low

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, done=0, error=0, tx_ready=1, busy=0. All counters and the shift register clear.
- Reset mid-transfer: lines are released immediately and no done/error pulse is produced.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer. fall = previous synced clk 1 and current synced clk 0.
- Accept: on tx_valid & tx_ready, latch {odd parity = ~^tx_data, tx_data}, set bit_cnt=0, go to INHIBIT. tx_valid is ignored while busy.
- INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS (1 cycle): ps2_clk_oe=1, ps2_dat_oe=1 (start bit 0). Then go to XMIT.
- XMIT: ps2_clk_oe=0 and ps2_dat_oe stays 1 until the first fall.
  - On each fall, bit_cnt increments and data is updated:
  - falls 1-8 drive data bits 0-7, LSB first (ps2_dat_oe = ~bit);
  - fall 9 drives parity;
  - fall 10 sets ps2_dat_oe=0 (stop bit 1, line released); go to ACK.
- ACK: on the next fall, sample synced data.
  - 0: go to WAIT_IDLE.
  - 1: pulse error, go to IDLE.
- WAIT_IDLE: wait until synced clk and data are both 1, then pulse done and go to IDLE.
- Timeout: a counter starts when RTS exits and clears on accept. If it reaches TIMEOUT_CYCLES before the ACK sample, release both lines, pulse error, go to IDLE.
  - WAIT_IDLE uses the same counter; on expiry it pulses error.
- done and error are never high in the same cycle. Each pulses exactly once per accepted byte.
- The outputs ps2_clk_oe and ps2_dat_oe are never both high, except in RTS.
- Glitch rule: any fall seen while in INHIBIT or RTS is ignored (the host is driving clk).

Test Plan:
- Reset: assert RST with lines idle high -> all oe=0, tx_ready=1, busy=0, done=error=0. Assert RST mid-XMIT -> oe drop to 0 within the same cycle as RST.
- Send 0xED with a device model (10-16 kHz clock, ack=0) -> clk_oe low for 5000 cycles; device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse; tx_ready returns to 1.
- Send 0xF4 -> parity bit sampled = 0; send 0xFF -> parity 1; both give a done pulse.
- Device returns ack=1 -> single error pulse, no done, back to IDLE with lines released.
- Device never clocks after RTS -> error pulse exactly TIMEOUT_CYCLES after RTS exit; oe both 0.
- tx_valid held high during a transfer with a changing tx_data -> only the originally latched byte is sent; the next byte is accepted only after done.
